layer_sched_ctrl: RTL and testbench
===================================

LAYER_SCHED_CTRL -- requirements
Module: layer_sched_ctrl

Interface
REQ-001 SHALL have parameter LAYER_NUM, default 3: number of layers per decoding iteration (≥2).
REQ-002 SHALL have parameter MAX_ITER, default 10: maximum decoding iterations per frame (≥2).
REQ-003 SHALL have parameter LOAD_CYCLES, default 4: channel-message load duration in cycles (≥1).
REQ-004 SHALL have read_clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 SHALL have rstn  input  1  asynchronous, active-low reset.
REQ-006 SHALL have frame_valid  input  1  new frame available.
REQ-007 SHALL have frame_ready  output  1  controller accepts a frame; a transfer occurs when frame_valid and frame_ready are both high.
REQ-008 SHALL have c2v_mem_we  input  1  CNU controller write-back pulse, meaning the current layer's C2V messages are stored.
REQ-009 SHALL have vnu_done  input  1  one-cycle pulse: VNU IB-RAM update for the current layer is complete.
REQ-010 SHALL have syndrome_valid, syndrome_pass  input  1 each  end-of-iteration parity-check result.
REQ-011 SHALL have layer_finish  output  1  one-cycle pulse: current layer is closed.
REQ-012 SHALL have vnu_update_pend  output  1  VNU IB-RAMs not yet consistent.
REQ-013 SHALL have termination  output  1  one-cycle pulse ending the frame.
REQ-014 SHALL have layer_idx  output  $clog2(LAYER_NUM)  current layer.
REQ-015 SHALL have iter_idx  output  $clog2(MAX_ITER)  current iteration.
REQ-016 SHALL have converged  output  1  frame ended on syndrome pass; held until the next frame is accepted.

Function
REQ-017 SHALL implement the states IDLE, LOAD, RUN, SYNC, CHECK and DONE.
REQ-018 SHALL, in IDLE, drive frame_ready=1 (0 in all other states); on a frame transfer it SHALL go to LOAD, clear layer_idx, iter_idx and converged, and load the load counter with LOAD_CYCLES-1.
REQ-019 SHALL, in LOAD, hold vnu_update_pend=1 and decrement the load counter; at count 0 it SHALL go to RUN, so that exactly LOAD_CYCLES cycles are spent in LOAD.
REQ-020 SHALL, in RUN, drive vnu_update_pend=0; on c2v_mem_we=1 it SHALL go to SYNC.
REQ-021 SHALL hold vnu_update_pend=1 throughout SYNC.
REQ-022 SHALL set a sticky vnu_seen flag on vnu_done in RUN or SYNC, and clear it in the cycle layer_finish is asserted; vnu_done in the same cycle as c2v_mem_we SHALL still be captured.
REQ-023 SHALL, in SYNC with vnu_seen=1 or vnu_done=1, assert layer_finish for exactly one cycle.
REQ-024 SHALL, at that layer_finish, increment layer_idx and return to RUN if layer_idx<LAYER_NUM-1; otherwise it SHALL go to CHECK with layer_idx unchanged.
REQ-025 SHALL, in CHECK, wait for syndrome_valid; syndrome_pass is ignored unless syndrome_valid=1.
REQ-026 SHALL, on syndrome_valid in CHECK: go to DONE if an early-termination condition holds (see Configuration) or iter_idx==MAX_ITER-1; otherwise increment iter_idx, wrap layer_idx to 0 and go to RUN.
REQ-027 SHALL, in DONE, assert termination for exactly one cycle and return to IDLE the next cycle; iter_idx SHALL never exceed MAX_ITER-1.
REQ-028 SHALL ignore frame_valid outside IDLE, and c2v_mem_we outside RUN.
REQ-029 SHALL treat an illegal state encoding as IDLE on the next cycle.

Reset
REQ-030 SHALL, on rstn=0 at any time including mid-frame, immediately force: state=IDLE, frame_ready=1, layer_finish=0, termination=0, vnu_update_pend=0, layer_idx=0, iter_idx=0, converged=0, vnu_seen=0, load counter=0.
REQ-031 SHALL start operation on the first read_clk edge after rstn deasserts.

Configuration
REQ-032 SHALL, with macro EARLY_TERM_EN defined, end the frame in CHECK on syndrome_valid=1 with syndrome_pass=1, setting converged=1 together with entering DONE.
REQ-033 SHALL, without EARLY_TERM_EN, ignore syndrome_pass, always run MAX_ITER iterations, and keep converged constant 0.

Verification
REQ-034 SHALL cover: reset, then frame_valid=1 for one cycle -> frame_ready falls next cycle; vnu_update_pend=1 for exactly 4 cycles; RUN entered with layer_idx=0.
REQ-035 SHALL cover: per layer, c2v_mem_we pulse followed by vnu_done 3 cycles later -> one layer_finish pulse per layer; layer_idx steps 0,1,2; CHECK entered after the third pulse.
REQ-036 SHALL cover: vnu_done in the same cycle as c2v_mem_we -> layer_finish on the first SYNC cycle, with no hang.
REQ-037 SHALL cover: EARLY_TERM_EN defined, syndrome_pass=1 at iter_idx=2 -> termination one cycle after DONE is entered, converged=1, iter_idx=2; without the macro, the same stimulus runs to iter_idx=9.
REQ-038 SHALL cover: syndrome_pass=0 for every iteration -> termination after 10 iterations (30 layer_finish pulses), converged=0.
REQ-039 SHALL cover: rstn pulsed low in SYNC at iter_idx=4 -> all outputs reset asynchronously; a following new frame starts cleanly from iter_idx=0.

Source files
------------

// File: rtl/layer_sched_ctrl_if.sv
// Layer scheduler handshake bundle: frame intake, per-layer CNU/VNU sync,
// syndrome result and schedule status outputs.
interface layer_sched_ctrl_if #(
  parameter int unsigned LAYER_NUM = 3,
  parameter int unsigned MAX_ITER  = 10
);
  localparam int unsigned LAYER_W = (LAYER_NUM > 1) ? $clog2(LAYER_NUM) : 1;
  localparam int unsigned ITER_W  = (MAX_ITER > 1) ? $clog2(MAX_ITER) : 1;

  logic               frame_valid;
  logic               frame_ready;
  logic               c2v_mem_we;
  logic               vnu_done;
  logic               syndrome_valid;
  logic               syndrome_pass;
  logic               layer_finish;
  logic               vnu_update_pend;
  logic               termination;
  logic [LAYER_W-1:0] layer_idx;
  logic [ITER_W-1:0]  iter_idx;
  logic               converged;

  // Controller side
  modport slave (
    input  frame_valid, c2v_mem_we, vnu_done, syndrome_valid, syndrome_pass,
    output frame_ready, layer_finish, vnu_update_pend, termination,
           layer_idx, iter_idx, converged
  );

  // Decoder datapath / frame source side
  modport master (
    output frame_valid, c2v_mem_we, vnu_done, syndrome_valid, syndrome_pass,
    input  frame_ready, layer_finish, vnu_update_pend, termination,
           layer_idx, iter_idx, converged
  );
endinterface

// File: rtl/layer_sched_ctrl.sv
// Layered LDPC decoder schedule controller.
// Sequences frame load, per-layer CNU write-back / VNU update sync, end of
// iteration syndrome check and frame termination.
// Optional feature macro: EARLY_TERM_EN (stop on syndrome pass, flag converged).
module layer_sched_ctrl #(
  parameter int unsigned LAYER_NUM   = 3,
  parameter int unsigned MAX_ITER    = 10,
  parameter int unsigned LOAD_CYCLES = 4
) (
  input  logic                read_clk,
  input  logic                rstn,
  layer_sched_ctrl_if.slave   bus
);

  localparam int unsigned LAYER_W = (LAYER_NUM > 1) ? $clog2(LAYER_NUM) : 1;
  localparam int unsigned ITER_W  = (MAX_ITER > 1) ? $clog2(MAX_ITER) : 1;
  localparam int unsigned LOAD_W  = (LOAD_CYCLES > 1) ? $clog2(LOAD_CYCLES) : 1;

  localparam logic [LAYER_W-1:0] LAST_LAYER = LAYER_W'(LAYER_NUM - 1);
  localparam logic [ITER_W-1:0]  LAST_ITER  = ITER_W'(MAX_ITER - 1);
  localparam logic [LOAD_W-1:0]  LOAD_INIT  = LOAD_W'(LOAD_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_RUN   = 3'd2,
    S_SYNC  = 3'd3,
    S_CHECK = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  state_t             state_q, state_d;
  logic [LOAD_W-1:0]  load_cnt_q, load_cnt_d;
  logic [LAYER_W-1:0] layer_q, layer_d;
  logic [ITER_W-1:0]  iter_q, iter_d;
  logic               conv_q, conv_d;
  logic               seen_q, seen_d;
  logic               ready_q, ready_d;
  logic               finish_q, finish_d;
  logic               pend_q, pend_d;
  logic               term_q, term_d;
  logic               early_hit;

  // Early-termination qualifier for the syndrome result
`ifdef EARLY_TERM_EN
  assign early_hit = bus.syndrome_pass;
`else
  logic unused_syndrome_pass;
  assign unused_syndrome_pass = bus.syndrome_pass;
  assign early_hit            = 1'b0;
`endif

  // State and registered outputs
  always_ff @(posedge read_clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= S_IDLE;
      load_cnt_q <= '0;
      layer_q    <= '0;
      iter_q     <= '0;
      conv_q     <= 1'b0;
      seen_q     <= 1'b0;
      ready_q    <= 1'b1;
      finish_q   <= 1'b0;
      pend_q     <= 1'b0;
      term_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      load_cnt_q <= load_cnt_d;
      layer_q    <= layer_d;
      iter_q     <= iter_d;
      conv_q     <= conv_d;
      seen_q     <= seen_d;
      ready_q    <= ready_d;
      finish_q   <= finish_d;
      pend_q     <= pend_d;
      term_q     <= term_d;
    end
  end

  // Next-state, counters and output decode (outputs follow the next state so
  // they line up with the state they describe)
  always_comb begin
    state_d    = state_q;
    load_cnt_d = load_cnt_q;
    layer_d    = layer_q;
    iter_d     = iter_q;
    conv_d     = conv_q;
    seen_d     = seen_q;
    finish_d   = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (bus.frame_valid) begin
          state_d    = S_LOAD;
          layer_d    = '0;
          iter_d     = '0;
          conv_d     = 1'b0;
          load_cnt_d = LOAD_INIT;
        end
      end

      S_LOAD: begin
        if (load_cnt_q == '0) begin
          state_d = S_RUN;
        end else begin
          load_cnt_d = load_cnt_q - LOAD_W'(1);
        end
      end

      S_RUN: begin
        // VNU completion may arrive early or together with the write-back
        if (bus.vnu_done) begin
          seen_d = 1'b1;
        end
        if (bus.c2v_mem_we) begin
          state_d = S_SYNC;
        end
      end

      S_SYNC: begin
        if (seen_q || bus.vnu_done) begin
          finish_d = 1'b1;
          seen_d   = 1'b0;
          if (layer_q < LAST_LAYER) begin
            layer_d = layer_q + LAYER_W'(1);
            state_d = S_RUN;
          end else begin
            state_d = S_CHECK;
          end
        end
      end

      S_CHECK: begin
        if (bus.syndrome_valid) begin
          if (early_hit || (iter_q == LAST_ITER)) begin
            state_d = S_DONE;
            if (early_hit) begin
              conv_d = 1'b1;
            end
          end else begin
            iter_d  = iter_q + ITER_W'(1);
            layer_d = '0;
            state_d = S_RUN;
          end
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    ready_d = (state_d == S_IDLE);
    pend_d  = (state_d == S_LOAD) || (state_d == S_SYNC);
    term_d  = (state_d == S_DONE);
  end

  assign bus.frame_ready     = ready_q;
  assign bus.layer_finish    = finish_q;
  assign bus.vnu_update_pend = pend_q;
  assign bus.termination     = term_q;
  assign bus.layer_idx       = layer_q;
  assign bus.iter_idx        = iter_q;
  assign bus.converged       = conv_q;

endmodule

// File: tb/tb_layer_sched_ctrl.sv
// Scoreboard bench for layer_sched_ctrl: stimulus pushes expected
// layer_finish / termination events, a negedge monitor pops and compares.
module tb_layer_sched_ctrl;

  localparam int LAYER_NUM   = 3;
  localparam int MAX_ITER    = 10;
  localparam int LOAD_CYCLES = 4;

`ifdef EARLY_TERM_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  typedef struct {
    bit term;
    int layer;
    int iter;
    bit conv;
  } exp_t;

  logic read_clk = 1'b0;
  logic rstn     = 1'b0;

  int   checks   = 0;
  int   errors   = 0;
  int   lf_count = 0;
  exp_t exp_q[$];

  layer_sched_ctrl_if #(.LAYER_NUM(LAYER_NUM), .MAX_ITER(MAX_ITER)) bus ();

  layer_sched_ctrl #(
    .LAYER_NUM  (LAYER_NUM),
    .MAX_ITER   (MAX_ITER),
    .LOAD_CYCLES(LOAD_CYCLES)
  ) dut (
    .read_clk(read_clk),
    .rstn    (rstn),
    .bus     (bus)
  );

  always #5 read_clk = ~read_clk;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  // Monitor: every output pulse must match the oldest expected event
  always @(negedge read_clk) begin
    exp_t e;
    if (rstn) begin
      if (bus.layer_finish) begin
        lf_count++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected layer_finish: layer_idx %0d iter_idx %0d", bus.layer_idx, bus.iter_idx);
        end else begin
          e = exp_q.pop_front();
          chk("lf event kind", 0, int'(e.term));
          chk("lf layer_idx", int'(bus.layer_idx), e.layer);
          chk("lf iter_idx", int'(bus.iter_idx), e.iter);
        end
      end
      if (bus.termination) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected termination: iter_idx %0d", bus.iter_idx);
        end else begin
          e = exp_q.pop_front();
          chk("term event kind", 1, int'(e.term));
          chk("term iter_idx", int'(bus.iter_idx), e.iter);
          chk("term layer_idx", int'(bus.layer_idx), e.layer);
          chk("term converged", int'(bus.converged), int'(e.conv));
        end
      end
    end
  end

  task automatic check_reset(input string tag);
    chk({tag, " frame_ready"}, int'(bus.frame_ready), 1);
    chk({tag, " layer_finish"}, int'(bus.layer_finish), 0);
    chk({tag, " termination"}, int'(bus.termination), 0);
    chk({tag, " vnu_update_pend"}, int'(bus.vnu_update_pend), 0);
    chk({tag, " layer_idx"}, int'(bus.layer_idx), 0);
    chk({tag, " iter_idx"}, int'(bus.iter_idx), 0);
    chk({tag, " converged"}, int'(bus.converged), 0);
  endtask

  // Accept a frame and measure the LOAD window
  task automatic start_frame();
    int cnt;
    @(negedge read_clk);
    chk("frame_ready in idle", int'(bus.frame_ready), 1);
    bus.frame_valid = 1'b1;
    @(negedge read_clk);
    bus.frame_valid = 1'b0;
    chk("frame_ready falls", int'(bus.frame_ready), 0);
    chk("converged cleared on accept", int'(bus.converged), 0);
    cnt = 0;
    while (bus.vnu_update_pend && cnt < 20) begin
      cnt++;
      @(negedge read_clk);
    end
    chk("LOAD pend cycles", cnt, LOAD_CYCLES);
    chk("RUN layer_idx", int'(bus.layer_idx), 0);
    chk("RUN iter_idx", int'(bus.iter_idx), 0);
    lf_count = 0;
  endtask

  // mode 0: vnu_done 3 cycles after c2v; 1: same cycle; 2: vnu_done before c2v
  task automatic do_layer(input int mode, input int l, input int it);
    exp_t e;
    e.term  = 1'b0;
    e.layer = (l < LAYER_NUM - 1) ? l + 1 : l;
    e.iter  = it;
    e.conv  = 1'b0;
    case (mode)
      0: begin
        bus.c2v_mem_we = 1'b1;
        @(negedge read_clk);
        bus.c2v_mem_we = 1'b0;
        @(negedge read_clk);
        chk("pend in SYNC", int'(bus.vnu_update_pend), 1);
        @(negedge read_clk);
        exp_q.push_back(e);
        bus.vnu_done = 1'b1;
        @(negedge read_clk);
        bus.vnu_done = 1'b0;
      end
      1: begin
        exp_q.push_back(e);
        bus.c2v_mem_we = 1'b1;
        bus.vnu_done   = 1'b1;
        @(negedge read_clk);
        bus.c2v_mem_we = 1'b0;
        bus.vnu_done   = 1'b0;
        @(negedge read_clk);
      end
      default: begin
        bus.vnu_done = 1'b1;
        @(negedge read_clk);
        bus.vnu_done = 1'b0;
        @(negedge read_clk);
        exp_q.push_back(e);
        bus.c2v_mem_we = 1'b1;
        @(negedge read_clk);
        bus.c2v_mem_we = 1'b0;
        @(negedge read_clk);
      end
    endcase
  endtask

  // End-of-iteration syndrome; pass is first shown without valid
  task automatic check_iter(input bit pass, input int it, output bit done);
    exp_t e;
    bus.syndrome_pass = 1'b1;
    repeat (2) @(negedge read_clk);
    done = (EARLY && pass) || (it == MAX_ITER - 1);
    if (done) begin
      e.term  = 1'b1;
      e.layer = LAYER_NUM - 1;
      e.iter  = it;
      e.conv  = EARLY && pass;
      exp_q.push_back(e);
    end
    bus.syndrome_valid = 1'b1;
    bus.syndrome_pass  = pass;
    @(negedge read_clk);
    bus.syndrome_valid = 1'b0;
    bus.syndrome_pass  = 1'b0;
    if (done) begin
      @(negedge read_clk);
      chk("back to idle", int'(bus.frame_ready), 1);
      chk("converged held", int'(bus.converged), int'(EARLY && pass));
      chk("final iter_idx held", int'(bus.iter_idx), it);
    end else begin
      chk("wrap layer_idx", int'(bus.layer_idx), 0);
      chk("next iter_idx", int'(bus.iter_idx), it + 1);
    end
  endtask

  task automatic run_frame(input int pass_iter, input bit mixed);
    bit done;
    int last;
    start_frame();
    done = 1'b0;
    last = 0;
    for (int it = 0; it < MAX_ITER && !done; it++) begin
      for (int l = 0; l < LAYER_NUM; l++) begin
        do_layer(mixed ? (l + it) % 3 : 0, l, it);
      end
      check_iter(it == pass_iter, it, done);
      last = it;
    end
    chk("layer_finish pulses per frame", lf_count, (last + 1) * LAYER_NUM);
  endtask

  initial begin
    bit done;
    bus.frame_valid    = 1'b0;
    bus.c2v_mem_we     = 1'b0;
    bus.vnu_done       = 1'b0;
    bus.syndrome_valid = 1'b0;
    bus.syndrome_pass  = 1'b0;
    rstn               = 1'b0;
    #12;
    check_reset("reset");
    @(negedge read_clk);
    rstn = 1'b1;

    // Pass at iteration 2: early stop only with the feature enabled
    run_frame(2, 1'b0);
    // Never passes: full MAX_ITER iterations
    run_frame(-1, 1'b0);
    // Mixed VNU/C2V orderings, pass at iteration 0
    run_frame(0, 1'b1);

    // Mid-frame asynchronous reset in SYNC at iteration 4
    start_frame();
    for (int it = 0; it < 4; it++) begin
      for (int l = 0; l < LAYER_NUM; l++) do_layer(0, l, it);
      check_iter(1'b0, it, done);
    end
    bus.c2v_mem_we = 1'b1;
    @(negedge read_clk);
    bus.c2v_mem_we = 1'b0;
    chk("pre-reset pend", int'(bus.vnu_update_pend), 1);
    chk("pre-reset iter_idx", int'(bus.iter_idx), 4);
    #2 rstn = 1'b0;
    #1 check_reset("async reset");
    @(negedge read_clk);
    rstn = 1'b1;

    // Clean restart after the reset
    run_frame(1, 1'b0);

    repeat (4) @(negedge read_clk);
    chk("scoreboard drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "timeout");
  end

endmodule
